// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Exports: state_e (IDLE/RUN/DONE) and clog2() for sizing the bit counter.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1; never less than one so WIDTH=1 still
    // gets a real counter register.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit half adder; two of these plus an OR form the full-adder slice.
// Ports: i_a, i_b (addend bits) -> o_s (sum bit), o_c (carry bit).
module half_adder_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice adds two WIDTH-bit operands LSB first.
// Ports: i_clk, i_rst_n, i_start, i_a, i_b -> o_busy, o_done, o_sum, o_c.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;

    logic             s1, c1, s, c2, cout;
    logic [WIDTH-1:0] res_shift;

    half_adder_cell u_ha1 (
        .i_a (a_q[0]),
        .i_b (b_q[0]),
        .o_s (s1),
        .o_c (c1)
    );

    half_adder_cell u_ha2 (
        .i_a (s1),
        .i_b (carry_q),
        .o_s (s),
        .o_c (c2)
    );

    assign cout = c1 | c2;

    // New sum bit enters at the MSB; written with shifts rather than a
    // concatenation so the WIDTH=1 case needs no empty slice.
    assign res_shift = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_d     = c_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    c_d     = cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_q     <= c_d;
        end
    end

    assign o_busy = (state_q == RUN);
    assign o_done = (state_q == DONE);
    assign o_sum  = sum_q;
    assign o_c    = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance.
// Stimulus pushes expected results; per-instance monitors pop on o_done.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    logic       start8, busy8, done8, c8;
    logic [7:0] a8, b8, sum8;
    logic       start1, busy1, done1, c1o;
    logic [0:0] a1, b1, sum1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start8),
        .i_a     (a8),
        .i_b     (b8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8),
        .o_c     (c8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_c     (c1o)
    );

    typedef struct {
        logic [7:0] sum;
        logic       c;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;

    int         bc8 = 0, bc1 = 0;
    logic [7:0] held8 = 8'h00;
    logic [0:0] held1 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bc8 = 0;
            held8 = sum8;
        end else begin
            if (busy8) begin
                checks++;
                if (sum8 !== held8) begin
                    failures++;
                    $display("FAIL sum8_hold got=%h want=%h", sum8, held8);
                end
                bc8++;
            end else begin
                held8 = sum8;
            end
            if (done8) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL done8_spurious got=1 want=0 cyc=%0d", cyc);
                end else begin
                    e8 = q8.pop_front();
                    if (sum8 !== e8.sum || c8 !== e8.c
                        || cyc != e8.cyc || bc8 != 8) begin
                        failures++;
                        $display("FAIL done8 got sum=%h c=%b cyc=%0d busy=%0d want sum=%h c=%b cyc=%0d busy=8",
                                 sum8, c8, cyc, bc8, e8.sum, e8.c, e8.cyc);
                    end
                end
                bc8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bc1 = 0;
            held1 = sum1;
        end else begin
            if (busy1) begin
                checks++;
                if (sum1 !== held1) begin
                    failures++;
                    $display("FAIL sum1_hold got=%b want=%b", sum1, held1);
                end
                bc1++;
            end else begin
                held1 = sum1;
            end
            if (done1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL done1_spurious got=1 want=0 cyc=%0d", cyc);
                end else begin
                    e1 = q1.pop_front();
                    if (sum1 !== e1.sum[0] || c1o !== e1.c
                        || cyc != e1.cyc || bc1 != 1) begin
                        failures++;
                        $display("FAIL done1 got s=%b c=%b cyc=%0d busy=%0d want s=%b c=%b cyc=%0d busy=1",
                                 sum1, c1o, cyc, bc1, e1.sum[0], e1.c, e1.cyc);
                    end
                end
                bc1 = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        q8.push_back('{exp[7:0], exp[8], cyc + 9});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b, input logic [1:0] exp);
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        q1.push_back('{{7'd0, exp[0]}, exp[1], cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (q8.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending8=%0d pending1=%0d want=0",
                     q8.size(), q1.size());
            q8.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_c8", 32'(c8), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        go8(8'h00, 8'h00, 9'h000);
        drain();
        go8(8'hFF, 8'h01, 9'h100);
        drain();
        go8(8'hA5, 8'h5A, 9'h0FF);
        drain();
        go8(8'hFF, 8'hFF, 9'h1FE);
        drain();

        go8(8'h0F, 8'h01, 9'h010);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        drain();

        go8(8'h80, 8'h80, 9'h100);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        q8.delete();
        chk("abort_busy8", 32'(busy8), 32'd0);
        chk("abort_done8", 32'(done8), 32'd0);
        chk("abort_sum8", 32'(sum8), 32'd0);
        chk("abort_c8", 32'(c8), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_busy8", 32'(busy8), 32'd0);
            chk("post_rst_done8", 32'(done8), 32'd0);
        end
        @(negedge clk);

        base = cyc;
        start8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
        q8.push_back('{8'h03, 1'b0, base + 9});
        q8.push_back('{8'h30, 1'b0, base + 19});
        q8.push_back('{8'h10, 1'b1, base + 29});
        @(negedge clk);
        a8 = 8'h10;
        b8 = 8'h20;
        repeat (10) @(negedge clk);
        a8 = 8'hF0;
        b8 = 8'h20;
        repeat (10) @(negedge clk);
        start8 = 1'b0;
        drain();

        go1(1'b0, 1'b0, 2'b00);
        drain();
        go1(1'b1, 1'b0, 2'b01);
        drain();
        go1(1'b0, 1'b1, 2'b01);
        drain();
        go1(1'b1, 1'b1, 2'b10);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
